sha256_nonce_sched: RTL

- Nonce scheduler and result collector for NCORES parallel double-SHA256 pipelines of fixed latency.
- Issues a nonce range, checks each core's final hash head word against a masked target, and aligns each hit back to its nonce.
- Queues golden nonces in a FIFO with a valid/ready read port.
- Sits between the work-loading host interface and the hash pipeline array; replaces the single-core fixed-match controller.

---
 rtl/sha256_nonce_sched.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sha256_nonce_sched.sv
// sha256_nonce_sched: issues nonce groups to NCORES fixed-latency hash
// pipelines, matches each core's head word against a masked target, and
// queues the winning nonces in a small valid/ready result FIFO.
module sha256_nonce_sched #(
  parameter int unsigned NCORES      = 4,
  parameter int unsigned PIPE_LAT    = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned STOP_ON_HIT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [31:0]            nonce_start,
  input  logic [31:0]            nonce_end,
  input  logic [31:0]            target,
  input  logic [31:0]            target_mask,
  output logic [31:0]            nonce_base,
  output logic                   issue_valid,
  input  logic [32*NCORES-1:0]   hash_head,
  output logic                   busy,
  output logic                   done,
  output logic                   res_valid,
  output logic [31:0]            res_nonce,
  input  logic                   res_ready,
  output logic [15:0]            hit_count,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t              r_state;
  logic [31:0]         r_base;
  logic                r_issue;
  logic                r_done;
  logic [31:0]         r_end;
  logic [31:0]         r_target;
  logic [31:0]         r_mask;

  logic                r_mv;
  logic [NCORES-1:0]   r_mhit;
  logic [31:0]         r_mbase;

  logic [31:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wp;
  logic [AW-1:0]       r_rp;
  logic [AW:0]         r_cnt;
  logic                r_ovf;
  logic [15:0]         r_hits;

  logic                w_lv [PIPE_LAT];
  logic [31:0]         w_lb [PIPE_LAT];
  logic                w_tap_v;
  logic [31:0]         w_tap_b;
  logic                w_any_lv;
  logic                w_in_flight;
  logic [NCORES-1:0]   w_hit;
  logic [31:0]         w_sel;
  logic [4:0]          w_nhit;
  logic                w_found;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_push_ok;
  logic [31:0]         w_push_nonce;
  logic [16:0]         w_hits_sum;
  logic                w_last;
  logic                w_start_acc;

  assign nonce_base  = r_base;
  assign issue_valid = r_issue;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign res_valid   = (r_cnt != '0);
  assign res_nonce   = r_mem[r_rp];
  assign hit_count   = r_hits;
  assign overflow    = r_ovf;

  assign w_start_acc = start && !abort && (r_state == ST_IDLE);
  // 33-bit compare so a range ending near 2^32-1 never wraps back to 0.
  assign w_last      = ({1'b0, r_base} + 33'(NCORES)) > {1'b0, r_end};

  // Stage 0 of the in-flight line is the issue register itself, so the
  // group presented after edge t reaches the tap for sampling at t+PIPE_LAT.
  assign w_lv[0] = r_issue;
  assign w_lb[0] = r_base;

  for (genvar k = 1; k < PIPE_LAT; k++) begin : g_dly
    logic        r_v;
    logic [31:0] r_b;
    // In-flight valid/base delay stage; abort drops the valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_b <= '0;
      end else begin
        r_v <= abort ? 1'b0 : w_lv[k-1];
        r_b <= w_lb[k-1];
      end
    end
    assign w_lv[k] = r_v;
    assign w_lb[k] = r_b;
  end

  assign w_tap_v = w_lv[PIPE_LAT-1];
  assign w_tap_b = w_lb[PIPE_LAT-1];

  // Any valid group still travelling down the delay line.
  always_comb begin
    w_any_lv = 1'b0;
    for (int unsigned k = 0; k < PIPE_LAT; k++) begin
      w_any_lv = w_any_lv | w_lv[k];
    end
  end

  assign w_in_flight = w_any_lv || r_mv;

  // Per-core masked target match, discarding nonces past the range end.
  always_comb begin
    w_hit = '0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      w_hit[i] = w_tap_v
              && (((hash_head[32*i +: 32] ^ r_target) & r_mask) == '0)
              && (({1'b0, w_tap_b} + 33'(i)) <= {1'b0, r_end});
    end
  end

  // Match register: one group per cycle, valid even when nothing hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mv    <= 1'b0;
      r_mhit  <= '0;
      r_mbase <= '0;
    end else if (abort) begin
      r_mv    <= 1'b0;
      r_mhit  <= '0;
    end else begin
      r_mv    <= w_tap_v;
      r_mhit  <= w_hit;
      r_mbase <= w_tap_b;
    end
  end

  // Lowest matching core index and total number of matching cores.
  always_comb begin
    w_sel   = '0;
    w_nhit  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < NCORES; i++) begin
      if (r_mhit[i]) begin
        w_nhit = w_nhit + 5'd1;
        if (!w_found) begin
          w_sel   = 32'(i);
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_push       = r_mv && (|r_mhit) && !abort;
  assign w_pop        = res_valid && res_ready;
  assign w_full       = (r_cnt == (AW+1)'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push_ok    = w_push && (!w_full || w_pop);
  assign w_push_nonce = r_mbase + w_sel;
  assign w_hits_sum   = {1'b0, r_hits} + 17'(w_nhit);

  // Control FSM: issue sequencing, drain and sticky completion flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_base   <= '0;
      r_issue  <= 1'b0;
      r_done   <= 1'b0;
      r_end    <= '0;
      r_target <= '0;
      r_mask   <= '0;
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_issue <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_end    <= nonce_end;
            r_target <= target;
            r_mask   <= target_mask;
            r_base   <= nonce_start;
            r_issue  <= 1'b1;
            r_done   <= 1'b0;
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_last || ((STOP_ON_HIT != 0) && w_push_ok)) begin
            r_issue <= 1'b0;
            r_state <= ST_DRAIN;
          end else begin
            r_base <= r_base + 32'(NCORES);
          end
        end
        ST_DRAIN: begin
          if (!w_in_flight) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Result FIFO pointers, occupancy, overflow and saturating hit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_hits <= '0;
    end else if (w_start_acc) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
      r_hits <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + AW'(1);
      if (w_pop)     r_rp <= r_rp + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_push && (!w_push_ok || (w_nhit > 5'd1))) r_ovf <= 1'b1;
      if (w_push) r_hits <= w_hits_sum[16] ? '1 : w_hits_sum[15:0];
    end
  end

  // Result FIFO storage.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= w_push_nonce;
  end

endmodule
